// File: rtl/prg_pkg.sv
// Shared constants for the 4-bit teaching CPU execute stage:
// data width, memory map and ALU result-select codes.
package prg_pkg;

    localparam int DW = 4;

    localparam logic [3:0] P_MEM   = 4'hC;
    localparam logic [3:0] P_IOIN  = 4'hD;
    localparam logic [3:0] P_IOOUT = 4'hE;

    localparam logic [3:0] ALU_IM  = 4'h0;
    localparam logic [3:0] ALU_MEM = 4'h1;
    localparam logic [3:0] ALU_IN  = 4'h2;
    localparam logic [3:0] ALU_R0  = 4'h3;
    localparam logic [3:0] ALU_R1  = 4'h4;
    localparam logic [3:0] ALU_AIM = 4'h5;
    localparam logic [3:0] ALU_BIM = 4'h6;
    localparam logic [3:0] ALU_AB  = 4'h7;
    localparam logic [3:0] ALU_SUB = 4'h8;

endpackage

// File: rtl/prg_alu.sv
// Combinational result/carry generator for the execute stage.
// Arithmetic is done 5 bits wide so bit 4 is the carry or borrow.
module prg_alu
    import prg_pkg::*;
(
    input  logic [3:0]    alu_sel,
    input  logic [DW-1:0] r0,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] im,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] res,
    output logic          co
);

    logic [DW:0] sum;

    always_comb begin
        sum = '0;
        case (alu_sel)
            ALU_IM:  sum = {1'b0, im};
            ALU_MEM: sum = {1'b0, rdata};
            ALU_IN:  sum = {1'b0, in_port};
            ALU_R0:  sum = {1'b0, r0};
            ALU_R1:  sum = {1'b0, r1};
            ALU_AIM: sum = {1'b0, r0} + {1'b0, im};
            ALU_BIM: sum = {1'b0, r1} + {1'b0, im};
            ALU_AB:  sum = {1'b0, r0} + {1'b0, r1};
            // wraps to 1xxxx exactly when r0 < r1
            ALU_SUB: sum = {1'b0, r0} - {1'b0, r1};
            default: sum = '0;
        endcase
        res = sum[DW-1:0];
        co  = sum[DW];
    end

endmodule

// File: rtl/prg_exec.sv
// Execute stage: R0, R1, CARRY, user memory and output port.
// Define PRG_EXEC_MMIO_EN to map IN_PORT/OUT_PORT into the address space.
module prg_exec
    import prg_pkg::*;
#(
    parameter logic [3:0] P_MEM   = 4'hC,
    parameter logic [3:0] P_IOIN  = 4'hD,
    parameter logic [3:0] P_IOOUT = 4'hE
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [7:0]    MC_CODE,
    input  logic          R0_LD,
    input  logic          R1_LD,
    input  logic          MEMW_LD,
    input  logic          MEMR_LD,
    input  logic          OUT_LD,
    input  logic          CARRY_LD,
    input  logic [3:0]    ALU_SEL,
    input  logic [3:0]    MEM_A,
    input  logic [DW-1:0] IN_PORT,
    output logic [DW-1:0] R0_REG,
    output logic [DW-1:0] R1_REG,
    output logic          CARRY,
    output logic [DW-1:0] OUT_PORT
);

    logic [DW-1:0] r0_q, r0_d;
    logic [DW-1:0] r1_q, r1_d;
    logic [DW-1:0] out_q, out_d;
    logic          carry_q, carry_d;
    logic [DW-1:0] mem_q [0:P_MEM];
    logic [DW-1:0] mem_d [0:P_MEM];

    logic [DW-1:0] rdata;
    logic [DW-1:0] res;
    logic          co;

    // read-select is implied by ALU_SEL; upper opcode bits belong to the decoder
    logic unused_ok;
    assign unused_ok = ^{MEMR_LD, MC_CODE[7:4], P_IOIN, P_IOOUT};

    always_comb begin
        rdata = '0;
        if (MEM_A <= P_MEM) begin
            rdata = mem_q[MEM_A];
        end
`ifdef PRG_EXEC_MMIO_EN
        else if (MEM_A == P_IOIN) begin
            rdata = IN_PORT;
        end
`endif
    end

    prg_alu u_alu (
        .alu_sel (ALU_SEL),
        .r0      (r0_q),
        .r1      (r1_q),
        .im      (MC_CODE[3:0]),
        .rdata   (rdata),
        .in_port (IN_PORT),
        .res     (res),
        .co      (co)
    );

    always_comb begin
        r0_d    = r0_q;
        r1_d    = r1_q;
        out_d   = out_q;
        carry_d = carry_q;
        mem_d   = mem_q;
        if (EN) begin
            if (R0_LD)    r0_d    = res;
            if (R1_LD)    r1_d    = res;
            if (OUT_LD)   out_d   = res;
            if (CARRY_LD) carry_d = co;
            if (MEMW_LD && (MEM_A <= P_MEM)) begin
                mem_d[MEM_A] = res;
            end
`ifdef PRG_EXEC_MMIO_EN
            if (MEMW_LD && (MEM_A == P_IOOUT)) begin
                out_d = res;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r0_q    <= '0;
            r1_q    <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            mem_q   <= mem_d;
        end
    end

    assign R0_REG   = r0_q;
    assign R1_REG   = r1_q;
    assign CARRY    = carry_q;
    assign OUT_PORT = out_q;

endmodule

// File: tb/tb_prg_exec.sv
// Directed bench for prg_exec; expectations adapt to PRG_EXEC_MMIO_EN.
module tb_prg_exec;

    logic       CLK = 1'b0;
    logic       RST, EN;
    logic [7:0] MC_CODE;
    logic       R0_LD, R1_LD, MEMW_LD, MEMR_LD, OUT_LD, CARRY_LD;
    logic [3:0] ALU_SEL, MEM_A, IN_PORT;
    logic [3:0] R0_REG, R1_REG, OUT_PORT;
    logic       CARRY;

    int n_pass = 0;
    int n_total = 0;

    prg_exec dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .MC_CODE  (MC_CODE),
        .R0_LD    (R0_LD),
        .R1_LD    (R1_LD),
        .MEMW_LD  (MEMW_LD),
        .MEMR_LD  (MEMR_LD),
        .OUT_LD   (OUT_LD),
        .CARRY_LD (CARRY_LD),
        .ALU_SEL  (ALU_SEL),
        .MEM_A    (MEM_A),
        .IN_PORT  (IN_PORT),
        .R0_REG   (R0_REG),
        .R1_REG   (R1_REG),
        .CARRY    (CARRY),
        .OUT_PORT (OUT_PORT)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        RST = 0; EN = 1; MC_CODE = 8'h00;
        R0_LD = 0; R1_LD = 0; MEMW_LD = 0; MEMR_LD = 0;
        OUT_LD = 0; CARRY_LD = 0; ALU_SEL = 4'h0; MEM_A = 4'h0;
    endtask

    // apply current inputs for one edge, then return them to idle
    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic ld(input logic r1, input logic [3:0] v);
        if (r1) R1_LD = 1; else R0_LD = 1;
        ALU_SEL = 4'h0; MC_CODE = {4'h0, v};
        tick();
    endtask

    logic mmio;
    logic [3:0] exp_out;

    initial begin
`ifdef PRG_EXEC_MMIO_EN
        mmio = 1'b1;
`else
        mmio = 1'b0;
`endif
        IN_PORT = 4'h0;
        idle();
        @(negedge CLK);
        RST = 1; R0_LD = 1; MC_CODE = 8'h0F;
        tick();
        chk("rst_r0", R0_REG, 4'h0);
        chk("rst_r1", R1_REG, 4'h0);
        chk("rst_carry", {3'b0, CARRY}, 4'h0);
        chk("rst_out", OUT_PORT, 4'h0);

        ld(0, 4'h7);
        chk("ld_r0", R0_REG, 4'h7);
        MEMW_LD = 1; MEM_A = 4'h3; ALU_SEL = 4'h3;
        tick();
        MEMR_LD = 1; R1_LD = 1; ALU_SEL = 4'h1; MEM_A = 4'h3;
        tick();
        chk("mem3_rd", R1_REG, 4'h7);

        ld(0, 4'h9); ld(1, 4'h8);
        ALU_SEL = 4'h7; R0_LD = 1; CARRY_LD = 1;
        tick();
        chk("add_res", R0_REG, 4'h1);
        chk("add_co", {3'b0, CARRY}, 4'h1);
        ld(0, 4'h0);
        chk("sticky_r0", R0_REG, 4'h0);
        chk("sticky_co", {3'b0, CARRY}, 4'h1);

        ALU_SEL = 4'h5; MC_CODE = 8'h0F; R0_LD = 1; CARRY_LD = 1;
        tick();
        chk("aim_res", R0_REG, 4'hF);
        chk("aim_co", {3'b0, CARRY}, 4'h0);
        ALU_SEL = 4'h6; MC_CODE = 8'h08; R1_LD = 1; CARRY_LD = 1;
        tick();
        chk("bim_res", R1_REG, 4'h0);
        chk("bim_co", {3'b0, CARRY}, 4'h1);

        ld(0, 4'h3); ld(1, 4'h5);
        ALU_SEL = 4'h8; R0_LD = 1; CARRY_LD = 1;
        tick();
        chk("sub_neg", R0_REG, 4'hE);
        chk("sub_borrow", {3'b0, CARRY}, 4'h1);
        ld(0, 4'h5); ld(1, 4'h3);
        ALU_SEL = 4'h8; R0_LD = 1; CARRY_LD = 1;
        tick();
        chk("sub_pos", R0_REG, 4'h2);
        chk("sub_noborrow", {3'b0, CARRY}, 4'h0);

        ALU_SEL = 4'h3; OUT_LD = 1;
        tick();
        chk("out_ld", OUT_PORT, 4'h2);
        exp_out = 4'h2;

        EN = 0; R0_LD = 1; MEMW_LD = 1; OUT_LD = 1; CARRY_LD = 1;
        ALU_SEL = 4'h0; MC_CODE = 8'h09; MEM_A = 4'h3;
        tick();
        chk("en0_r0", R0_REG, 4'h2);
        chk("en0_out", OUT_PORT, 4'h2);
        chk("en0_co", {3'b0, CARRY}, 4'h0);
        ALU_SEL = 4'h1; MEM_A = 4'h3; R1_LD = 1;
        tick();
        chk("en0_mem", R1_REG, 4'h7);

        ALU_SEL = 4'h0; MC_CODE = 8'h0A; R0_LD = 1; R1_LD = 1;
        tick();
        chk("both_r0", R0_REG, 4'hA);
        chk("both_r1", R1_REG, 4'hA);

        ALU_SEL = 4'h0; MC_CODE = 8'h06; MEMW_LD = 1; MEM_A = 4'hC;
        tick();
        ALU_SEL = 4'h1; MEM_A = 4'hC; R0_LD = 1;
        tick();
        chk("mem_top", R0_REG, 4'h6);

        IN_PORT = 4'hA;
        ld(0, 4'h5);
        ALU_SEL = 4'h1; MEM_A = 4'hD; MEMR_LD = 1; R0_LD = 1;
        tick();
        chk("mmio_rd", R0_REG, mmio ? 4'hA : 4'h0);
        ld(0, 4'h5);
        ALU_SEL = 4'h3; MEM_A = 4'hE; MEMW_LD = 1;
        tick();
        if (mmio) exp_out = 4'h5;
        chk("mmio_wr", OUT_PORT, exp_out);
        ALU_SEL = 4'h2; R1_LD = 1;
        tick();
        chk("in_sel", R1_REG, 4'hA);

        ALU_SEL = 4'h0; MC_CODE = 8'h09; MEMW_LD = 1; MEM_A = 4'hF;
        tick();
        chk("wr_f_out", OUT_PORT, exp_out);
        ALU_SEL = 4'h1; MEM_A = 4'hF; R0_LD = 1;
        tick();
        chk("rd_f", R0_REG, 4'h0);

        ALU_SEL = 4'h9; R1_LD = 1; CARRY_LD = 1;
        tick();
        chk("sel9", R1_REG, 4'h0);

        ld(0, 4'h4);
        RST = 1; R0_LD = 1; ALU_SEL = 4'h0; MC_CODE = 8'h07;
        tick();
        chk("rst_pri_r0", R0_REG, 4'h0);
        chk("rst_pri_out", OUT_PORT, 4'h0);
        ALU_SEL = 4'h1; MEM_A = 4'h3; R1_LD = 1;
        tick();
        chk("rst_mem", R1_REG, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prg_exec.md
# prg_exec

Execute stage of the 4-bit teaching CPU, directly downstream of the program decoder. It holds the architectural state: R0, R1, the carry flag, 13 words of user memory and the output port. Each enabled clock it applies the decoder's load pulses, ALU select and memory address to commit one instruction. R0, R1 and CARRY feed back to the decoder and the program counter.

## Interface
Parameters:
- P_MEM, 4'hC: highest user-memory address; words 0..P_MEM are implemented.
- P_IOIN, 4'hD: memory-mapped input-port address.
- P_IOOUT, 4'hE: memory-mapped output-port address.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- CLK, input, 1: system clock; all state changes on its rising edge.
- RST, input, 1: synchronous active-high reset.
- EN, input, 1: execute enable; load pulses are honoured only when EN=1.
- MC_CODE, input, 8: current machine code; only [3:0] (Im) is used.
- R0_LD, R1_LD, input, 1 each: register load pulses.
- MEMW_LD, MEMR_LD, input, 1 each: memory write and memory read-select.
- OUT_LD, input, 1: output-port load.
- CARRY_LD, input, 1: carry-flag load.
- ALU_SEL, input, 4: result source select.
- MEM_A, input, 4: memory address.
- IN_PORT, input, 4: external input switches.
- R0_REG, R1_REG, output, 4 each: register contents.
- CARRY, output, 1: registered carry/borrow flag.
- OUT_PORT, output, 4: registered output port.

## Operation
- RDATA (combinational memory read):
  - MEM_A ≤ P_MEM gives mem[MEM_A].
  - MEM_A = P_IOIN gives IN_PORT (with the macro, see Configuration).
  - Any other address gives 4'h0.
- ALU result RES[3:0] and carry-out CO, selected by ALU_SEL:
  - 0: Im. 1: RDATA. 2: IN_PORT. 3: R0. 4: R1. For all of these, CO=0.
  - 5: R0+Im. 6: R1+Im. 7: R0+R1. Computed as a 5-bit sum; RES is the low 4 bits and CO is bit 4.
  - 8: R0−R1. Computed as a 5-bit difference; CO=1 exactly when R0<R1 (borrow).
  - 9..F: RES=0, CO=0.
- Commit at a clock edge with EN=1 and RST=0:
  - R0_LD: R0 ← RES. R1_LD: R1 ← RES. If both are asserted, both load RES.
  - CARRY_LD: CARRY ← CO. CARRY holds otherwise; it is sticky across non-arithmetic instructions.
  - OUT_LD: OUT_PORT ← RES.
  - MEMW_LD with MEM_A ≤ P_MEM: mem[MEM_A] ← RES. Writes above P_MEM are dropped, apart from the P_IOOUT case in Configuration.
- A read and a write to the same address in one cycle: the read returns the old contents, and the write lands at the edge.
- EN=0: no state changes, regardless of the load pulses.

## Timing
- Reset: at a rising edge with RST=1, R0_REG, R1_REG, CARRY, OUT_PORT and all 13 memory words become 4'h0. RST overrides EN and all load pulses.
- If RST is asserted in the middle of an instruction, that instruction is discarded.
- Latency is one cycle: results are visible on the outputs the cycle after the enabled edge.
- CARRY is registered only. There is no combinational path from the inputs to CARRY, so the decoder-to-execute loop is free of combinational loops.
- RDATA and RES are combinational; the critical path is MEM_A → read mux → adder → register D input.

## Configuration
- PRG_EXEC_MMIO_EN defined:
  - Reads at P_IOIN return IN_PORT.
  - A MEMW_LD write at P_IOOUT sets OUT_PORT ← RES.
  - If OUT_LD is also asserted, it loads the same value.
- PRG_EXEC_MMIO_EN undefined:
  - Reads at P_IOIN return 4'h0.
  - Writes at P_IOOUT are dropped; OUT_PORT changes only via OUT_LD.
  - ALU_SEL=2 still returns IN_PORT.

## Structure
- Shared package `prg_pkg` holds:
  - the ALU_SEL code constants (0–8);
  - P_MEM, P_IOIN and P_IOOUT;
  - the data width of 4.
- One sub-module, `prg_alu`: a combinational RES/CO generator taking ALU_SEL, R0, R1, Im, RDATA and IN_PORT.
- Registers and memory stay in `prg_exec`.

## Test plan
- Reset and load:
  - Reset, then EN=1, R0_LD=1, ALU_SEL=0, Im=4'h7 → R0_REG=7.
  - Then MEMW_LD=1, MEM_A=3, ALU_SEL=3 → mem[3]=7.
  - Then MEMR_LD=1, R1_LD=1, ALU_SEL=1, MEM_A=3 → R1_REG=7.
- Add with overflow:
  - R0=9, R1=8, ALU_SEL=7, R0_LD, CARRY_LD → R0=1, CARRY=1.
  - Next cycle with Im=0, ALU_SEL=0, R0_LD (no CARRY_LD) → CARRY stays 1.
- Subtract:
  - R0=3, R1=5, ALU_SEL=8 → R0=E, CARRY=1.
  - R0=5, R1=3 → R0=2, CARRY=0.
- Enable and reset priority:
  - EN=0 with R0_LD, MEMW_LD, OUT_LD asserted → no state change.
  - RST=1 together with R0_LD, EN=1 → R0=0.
- Memory-mapped I/O with PRG_EXEC_MMIO_EN:
  - IN_PORT=A, MEMR_LD at D → R0=A.
  - Write of R0=5 at E → OUT_PORT=5.
- Memory-mapped I/O without PRG_EXEC_MMIO_EN:
  - The same stimulus gives R0=0 and OUT_PORT unchanged.
  - Any write at F is dropped, and a read at F returns 0.
